// File: rtl/flit_tx.sv
// Credit-based output-link transmitter with wormhole framing.
// Drives the downstream buffer write port one registered flit per cycle.
module flit_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [1:0]                       in_type,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [1:0]                       out_type,
  input  logic                             credit_in,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   credits,
  output logic                             busy,
  output logic                             err
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]            out_type_q, out_type_d;
  logic                  err_q, err_d;

  logic accept;
  logic legal;
  logic send;
  logic drop;
  logic ovf;

  // Ready comes only from the registered credit count.
  assign in_ready = (credits_q != '0);
  assign accept   = in_valid && in_ready;

  // Framing check: IDLE takes head/single, PKT takes body/tail.
  always_comb begin
    legal = 1'b0;
    unique case (state_q)
      S_IDLE: legal = in_type[0];
      S_PKT:  legal = !in_type[0];
      default: legal = 1'b0;
    endcase
  end

  assign send = accept && legal;
  assign drop = accept && !legal;
  assign ovf  = credit_in && !send && (credits_q == FULL);

  // Next-state, credit and output-register computation.
  always_comb begin
    state_d     = state_q;
    credits_d   = credits_q;
    out_valid_d = send;
    out_data_d  = out_data_q;
    out_type_d  = out_type_q;
    err_d       = drop || ovf;

    if (send) begin
      out_data_d = in_data;
      out_type_d = in_type;
    end

    unique case (1'b1)
      (send && !credit_in): credits_d = credits_q - CW'(1);
      (!send && credit_in && !ovf): credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase

    unique case (state_q)
      S_IDLE: if (send && in_type == T_HEAD) state_d = S_PKT;
      S_PKT:  if (send && in_type == T_TAIL) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered FSM state, credit count and link outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      credits_q   <= FULL;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_type_q  <= T_BODY;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_type_q  <= out_type_d;
      err_q       <= err_d;
    end
  end

  assign credits   = credits_q;
  assign busy      = (state_q == S_PKT);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_type  = out_type_q;
  assign err       = err_q;

endmodule

// File: doc/flit_tx.md
# flit_tx

Credit-based output-link transmitter for one router output port. It accepts flits from the crossbar and drives them into the downstream router's input `buffer`, one registered flit per cycle, using that buffer's write interface. It tracks free downstream slots with a credit counter that starts at the buffer depth and is replenished by credit pulses returned when the downstream buffer is read. It also enforces wormhole packet framing, holding the port from a head flit until the matching tail flit.

## Interface
Parameters:
- `DATA_WIDTH`, 8: flit payload width.
- `BUF_DEPTH`, 8: depth of the downstream input buffer, which is the initial credit count. Must be ≥ 1.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a flit is offered by the crossbar.
- `in_data` in DATA_WIDTH: flit payload.
- `in_type` in 2: flit type. 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head and tail).
- `in_ready` out 1: transmitter can take a flit this cycle.
- `out_valid` out 1: write enable to the downstream buffer (`wr_en`).
- `out_data` out DATA_WIDTH: flit to the downstream buffer (`data_in`).
- `out_type` out 2: flit type travelling with `out_data`.
- `credit_in` in 1: one-cycle pulse; the downstream buffer freed one slot.
- `credits` out $clog2(BUF_DEPTH+1): current credit count.
- `busy` out 1: a packet is in progress and the port is locked.
- `err` out 1: one-cycle pulse on a protocol violation.

## Operation
- Handshake: a flit is accepted when `in_valid && in_ready`.
- `in_ready` = (`credits` != 0). It is driven from the registered count only, with no combinational path from `credit_in` or `in_valid`.
- State machine, two states:
  - IDLE (`busy`=0): an accepted head flit moves to PKT. A single flit is sent and the state stays IDLE.
  - PKT (`busy`=1): body flits are sent and the state stays PKT. A tail flit is sent and the state returns to IDLE.
- Framing violations:
  - Body or tail offered in IDLE: dropped.
  - Head or single offered in PKT: dropped.
  - A dropped flit consumes no credit, sets no `out_valid`, pulses `err` next cycle, and leaves the state unchanged. The handshake still completes, so upstream is not stalled.
- Credit counter:
  - Sending a flit decrements the count.
  - `credit_in` increments the count.
  - Both in the same cycle leave it unchanged.
- Credit overflow: `credit_in` with `credits` == BUF_DEPTH and no send in that cycle saturates the count at BUF_DEPTH and pulses `err`.
- Underflow is impossible, because `in_ready` is 0 when the count is 0.
- Output register: a sent flit is loaded into `out_data`/`out_type` with `out_valid`=1 for exactly one cycle. When nothing is sent, `out_valid`=0 and `out_data`/`out_type` hold their last values.

## Timing
- Reset (asynchronous, `rst`=0) sets:
  - `credits`=BUF_DEPTH
  - state IDLE, `busy`=0
  - `out_valid`=0, `out_data`=0, `out_type`=0
  - `err`=0
  - `in_ready`=1
- Reset mid-packet abandons the packet: the state returns to IDLE and credits reload to BUF_DEPTH. Any flits already in flight are the system's concern.
- Latency: accept in cycle N gives `out_valid`=1 in cycle N+1.
- Throughput: one flit per cycle while credits last.
- Credit timing: `credit_in` in cycle N is visible in `credits` and `in_ready` in cycle N+1.
- From `credits`=0, a credit pulse in cycle N allows an accept in N+1.
- `busy` updates in the cycle after the accepted head or tail.
- `err` is a one-cycle pulse, registered, in the cycle after the violation.

## Test plan
- Reset, then send a 4-flit packet (head 0x04, body 0x05, body 0x06, tail 0x07) on consecutive cycles with no credits returned:
  - `out_valid` high for 4 cycles, one cycle after each accept, with the same data in order.
  - `credits` steps 8→4.
  - `busy` is 1 after the head and 0 after the tail.
- Offer 9 single flits (0x04..0x0C) back-to-back with no credits:
  - 8 are accepted.
  - `in_ready`=0 with `credits`=0, and the 9th is held.
  - Pulse `credit_in` once: the 9th is accepted one cycle later and `credits` returns to 0.
- Credit return and send in the same cycle with `credits`=3: `credits` stays 3.
- Body flit 0x22 offered in IDLE:
  - no `out_valid`, `credits` unchanged, `err` pulses once, `busy`=0.
- Head flit offered during a packet: the same drop and `err` behaviour, and `busy` stays 1.
- `credit_in` with `credits`=8: count stays 8 and `err` pulses.
- Assert `rst`=0 asynchronously mid-packet:
  - immediately `busy`=0, `credits`=8, `out_valid`=0.
  - A new head is accepted after release.
